// File: rtl/vga_draw_pkg.sv
// Shared types and screen constants for the VGA draw arbiter.
package vga_draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SCAN,
    FLUSH,
    DONE
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] KEY_COLOUR = 3'b000;

endpackage

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// Round-robin requester select. The search starts at the pointer and wraps;
// the pointer moves just past a requester when its blit completes.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [GW-1:0]   last_grant,
  output logic            any_req,
  output logic [GW-1:0]   sel_idx
);

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] cand;

  // first requester at or above the pointer, wrapping around
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // pointer update on completion of the granted blit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= (last_grant == GW'(NREQ - 1)) ? '0 : last_grant + 1'b1;
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares one VGA plot port between NREQ rectangle blitters.
//
// state | meaning
// IDLE  | waiting for any request; picks next requester round-robin
// LATCH | captures the granted rectangle, clears the raster counters
// SCAN  | one ROM read per cycle in raster order
// FLUSH | last pipelined pixel plots
// DONE  | one-cycle done pulse to the granted requester
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int AW   = 15,
  parameter int CW   = COLOUR_W,
  parameter int XMAX = SCREEN_W,
  parameter int YMAX = SCREEN_H,
  parameter logic [CW-1:0] KEY = CW'(KEY_COLOUR)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          key_en,
  input  logic [NREQ*XW-1:0]       x0,
  input  logic [NREQ*YW-1:0]       y0,
  input  logic [NREQ*XW-1:0]       w,
  input  logic [NREQ*YW-1:0]       h,
  input  logic [NREQ*AW-1:0]       base,
  output logic [AW-1:0]            rom_addr,
  input  logic [CW-1:0]            rom_data,
  output logic [XW-1:0]            vga_x,
  output logic [YW-1:0]            vga_y,
  output logic [CW-1:0]            vga_colour,
  output logic                     vga_plot,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant
);

  localparam int GW  = $clog2(NREQ);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW:0] X_LIM = XW1'(XMAX);
  localparam logic [YW:0] Y_LIM = YW1'(YMAX);

  state_t        state, state_nxt;
  logic          any_req;
  logic [GW-1:0] sel_idx;

  logic [XW-1:0] x0_r, w_r, cx, w_sel;
  logic [YW-1:0] y0_r, h_r, cy, h_sel;
  logic          key_r;
  logic [XW:0]   px_r;
  logic [YW:0]   py_r;
  logic          pipe_valid;
  logic          last_px;
  logic          transparent;

  assign w_sel   = w[grant*XW +: XW];
  assign h_sel   = h[grant*YW +: YW];
  assign last_px = (cx == w_r - 1'b1) && (cy == h_r - 1'b1);

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .advance    (state == DONE),
    .last_grant (grant),
    .any_req    (any_req),
    .sel_idx    (sel_idx)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state plus the outputs decoded directly from the state
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = LATCH;
      end
      LATCH:   state_nxt = (w_sel == '0 || h_sel == '0) ? DONE : SCAN;
      SCAN:    if (last_px) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE: begin
        done[grant] = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant, captured rectangle, raster counters and ROM address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      key_r    <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      rom_addr <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) grant <= sel_idx;
        LATCH: begin
          x0_r  <= x0[grant*XW +: XW];
          y0_r  <= y0[grant*YW +: YW];
          w_r   <= w_sel;
          h_r   <= h_sel;
          key_r <= key_en[grant];
          cx    <= '0;
          cy    <= '0;
          // an empty rectangle leaves the ROM port untouched
          if (w_sel != '0 && h_sel != '0) rom_addr <= base[grant*AW +: AW];
        end
        SCAN: if (!last_px) begin
          rom_addr <= rom_addr + 1'b1;
          if (cx == w_r - 1'b1) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // coordinates of the pixel whose colour arrives from the ROM next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      px_r       <= '0;
      py_r       <= '0;
    end else begin
      pipe_valid <= (state == SCAN);
      if (state == SCAN) begin
        px_r <= {1'b0, x0_r} + {1'b0, cx};
        py_r <= {1'b0, y0_r} + {1'b0, cy};
      end
    end
  end

  assign transparent = key_r && (rom_data == KEY);
  assign vga_x       = px_r[XW-1:0];
  assign vga_y       = py_r[YW-1:0];
  assign vga_colour  = pipe_valid ? rom_data : '0;
  assign vga_plot    = pipe_valid && (px_r < X_LIM) && (py_r < Y_LIM) && !transparent;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: directed table, round-robin and reset sequences,
// and randomized multi-requester rounds against a rule-level model.
`timescale 1ns/1ps
module tb_vga_draw_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int AW   = 15;
  localparam int CW   = 3;
  localparam int GW   = 2;
  localparam int MAXC = 512;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   key_en;
  logic [NREQ*XW-1:0] x0, w;
  logic [NREQ*YW-1:0] y0, h;
  logic [NREQ*AW-1:0] base;
  logic [AW-1:0]     rom_addr;
  logic [CW-1:0]     rom_data = '0;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_colour;
  logic              vga_plot;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [GW-1:0]     grant;

  int p_x0[NREQ]   = '{default: 0};
  int p_y0[NREQ]   = '{default: 0};
  int p_w[NREQ]    = '{default: 0};
  int p_h[NREQ]    = '{default: 0};
  int p_base[NREQ] = '{default: 0};
  int p_key[NREQ]  = '{default: 0};

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign x0[i*XW +: XW]   = XW'(p_x0[i]);
    assign y0[i*YW +: YW]   = YW'(p_y0[i]);
    assign w[i*XW +: XW]    = XW'(p_w[i]);
    assign h[i*YW +: YW]    = YW'(p_h[i]);
    assign base[i*AW +: AW] = AW'(p_base[i]);
    assign key_en[i]        = (p_key[i] != 0);
  end

  vga_draw_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .key_en     (key_en),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .base       (base),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done),
    .busy       (busy),
    .grant      (grant)
  );

  always #5 clk = ~clk;

  // sprite ROM: colour is the low address bits, one cycle of latency
  always @(posedge clk) rom_data <= rom_addr[2:0];

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  int ncyc;
  int lg_plot[MAXC];
  int lg_xyc[MAXC];
  int lg_addr[MAXC];
  int lg_done[MAXC];
  int lg_grant[MAXC];

  typedef struct {
    int idx; int x0; int y0; int w; int h; int base; int key;
    int e_plots; int e_done; int e_first;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_ptr = 0;
  endtask

  // raise the masked requests in an IDLE cycle (cycle 0), log each cycle,
  // drop each request at its done pulse, finish in the following IDLE cycle
  task automatic run_blits(input int mask, input int budget, output bit ok);
    int pend;
    pend = mask;
    req  = NREQ'(mask);
    ncyc = 0;
    ok   = 1'b1;
    while (pend != 0) begin
      if (ncyc >= budget || ncyc >= MAXC) begin
        ok = 1'b0;
        break;
      end
      lg_plot[ncyc]  = int'(vga_plot);
      lg_xyc[ncyc]   = (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour);
      lg_addr[ncyc]  = int'(rom_addr);
      lg_done[ncyc]  = int'(done);
      lg_grant[ncyc] = int'(grant);
      pend = pend & ~int'(done);
      req  = req & ~done;
      ncyc++;
      if (pend != 0) tick();
    end
    req = '0;
    tick();
  endtask

  // model: round-robin order from the pending set, then each blit's pixels
  // in raster order with clip/key rules and the fixed latency
  task automatic check_run(input string tag, input int mask);
    int e_plot[MAXC];
    int e_xyc[MAXC];
    int pend, start, g, n, dc, px, py, a, col, abad, bad, ecount, acount, nd, nonhot, idx;
    pend   = mask;
    start  = 0;
    ecount = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_plot[c] = 0;
      e_xyc[c]  = 0;
    end
    while (pend != 0) begin
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        idx = (m_ptr + i) % NREQ;
        if (g < 0 && ((pend >> idx) & 1) != 0) g = idx;
      end
      n    = p_w[g] * p_h[g];
      dc   = start + ((n == 0) ? 2 : n + 3);
      abad = 0;
      for (int k = 0; k < n; k++) begin
        px  = p_x0[g] + k % p_w[g];
        py  = p_y0[g] + k / p_w[g];
        a   = (p_base[g] + k) % (1 << AW);
        col = a % 8;
        if (start + 2 + k >= ncyc || lg_addr[start + 2 + k] != a) abad++;
        if (px < 160 && py < 120 && !(p_key[g] != 0 && col == 0) && start + 3 + k < MAXC) begin
          e_plot[start + 3 + k] = 1;
          e_xyc[start + 3 + k]  = (px << 16) | (py << 8) | col;
          ecount++;
        end
      end
      if (n == 0)
        for (int c = start; c <= dc && c < ncyc; c++)
          if (lg_addr[c] != lg_addr[start]) abad++;
      chk($sformatf("%s addr g%0d", tag, g), abad, 0);
      chk($sformatf("%s done g%0d", tag, g), (dc < ncyc) ? lg_done[dc] : -1, 1 << g);
      chk($sformatf("%s grant g%0d", tag, g), (dc < ncyc) ? lg_grant[dc] : -1, g);
      m_ptr = (g + 1) % NREQ;
      pend  = pend & ~(1 << g);
      start = dc + 1;
    end
    bad = 0; acount = 0; nd = 0; nonhot = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (lg_plot[c] != 0) acount++;
      if (lg_plot[c] != e_plot[c] || (e_plot[c] != 0 && lg_xyc[c] != e_xyc[c])) bad++;
      if (lg_done[c] != 0) begin
        nd++;
        if ($countones(lg_done[c]) != 1) nonhot++;
      end
    end
    chk({tag, " plot mismatches"}, bad, 0);
    chk({tag, " plot count"}, acount, ecount);
    chk({tag, " done count"}, nd, $countones(mask));
    chk({tag, " done onehot"}, nonhot, 0);
  endtask

  task automatic blit(input string tag, input int mask);
    bit ok;
    run_blits(mask, 400, ok);
    if (ok) begin
      check_run(tag, mask);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no completion after %0d cycles, required all done", tag, ncyc);
      do_reset();
    end
  endtask

  function automatic int done_order();
    int ord = 0;
    for (int c = 0; c < ncyc; c++)
      if (lg_done[c] != 0) ord = ord * 10 + $clog2(lg_done[c]) + 1;
    return ord;
  endfunction

  initial begin
    vec_t tbl[7];
    int first, dcyc, np, mask;

    tbl[0] = '{1,  10,  20, 3, 2,   100, 0, 6, 9, 3};
    tbl[1] = '{0, 158,   5, 4, 1,     0, 0, 2, 7, 3};
    tbl[2] = '{2,   5,   5, 3, 1,     7, 1, 2, 6, 3};
    tbl[3] = '{2,   5,   5, 3, 1,     7, 0, 3, 6, 3};
    tbl[4] = '{3,  40,  40, 0, 5,    50, 0, 0, 2, -1};
    tbl[5] = '{1,   0, 118, 1, 4,     2, 0, 2, 7, 3};
    tbl[6] = '{0,  20,  30, 4, 1, 32766, 1, 3, 7, 3};

    // reset values
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset plot", vga_plot, 0);
    chk("reset done", done, 0);
    chk("reset grant", grant, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset xyc", (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour), 0);
    reset = 1'b0;
    tick();
    m_ptr = 0;

    // simultaneous requests, then a lone requester 0
    p_x0[0] = 0;   p_y0[0] = 0;   p_w[0] = 2; p_h[0] = 1; p_base[0] = 10;  p_key[0] = 0;
    p_x0[1] = 30;  p_y0[1] = 40;  p_w[1] = 1; p_h[1] = 2; p_base[1] = 20;  p_key[1] = 0;
    p_x0[3] = 100; p_y0[3] = 100; p_w[3] = 2; p_h[3] = 2; p_base[3] = 200; p_key[3] = 1;
    blit("rr1", 4'b1011);
    chk("rr1 order", done_order(), 124);
    blit("rr2", 4'b0001);
    chk("rr2 order", done_order(), 1);

    // directed table
    foreach (tbl[t]) begin
      p_x0[tbl[t].idx]   = tbl[t].x0;
      p_y0[tbl[t].idx]   = tbl[t].y0;
      p_w[tbl[t].idx]    = tbl[t].w;
      p_h[tbl[t].idx]    = tbl[t].h;
      p_base[tbl[t].idx] = tbl[t].base;
      p_key[tbl[t].idx]  = tbl[t].key;
      blit($sformatf("vec%0d", t), 1 << tbl[t].idx);
      first = -1; dcyc = -1; np = 0;
      for (int c = 0; c < ncyc; c++) begin
        if (lg_plot[c] != 0) begin
          np++;
          if (first < 0) first = c;
        end
        if (lg_done[c] != 0 && dcyc < 0) dcyc = c;
      end
      chk($sformatf("vec%0d plots", t), np, tbl[t].e_plots);
      chk($sformatf("vec%0d done cycle", t), dcyc, tbl[t].e_done);
      chk($sformatf("vec%0d first plot", t), first, tbl[t].e_first);
    end

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < NREQ; i++) begin
        p_x0[i]   = ($urandom_range(0, 1) != 0) ? $urandom_range(145, 200) : $urandom_range(0, 144);
        p_y0[i]   = ($urandom_range(0, 1) != 0) ? $urandom_range(105, 127) : $urandom_range(0, 104);
        p_w[i]    = $urandom_range(0, 6);
        p_h[i]    = $urandom_range(0, 5);
        p_base[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(32760, 32767) : $urandom_range(0, 32767);
        p_key[i]  = $urandom_range(0, 1);
      end
      blit($sformatf("rnd%0d", r), mask);
    end

    // reset in the middle of a blit
    p_x0[2] = 50; p_y0[2] = 50; p_w[2] = 1;  p_h[2] = 1;  p_base[2] = 5; p_key[2] = 0;
    blit("pre", 4'b0100);
    p_x0[1] = 0;  p_y0[1] = 0;  p_w[1] = 10; p_h[1] = 10; p_base[1] = 0; p_key[1] = 0;
    req = 4'b0010;
    repeat (12) tick();
    chk("mid plot before reset", vga_plot, 1);
    chk("mid grant before reset", grant, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset plot", vga_plot, 0);
    chk("mid reset done", done, 0);
    chk("mid reset grant", grant, 0);
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_ptr = 0;
    p_x0[3] = 60; p_y0[3] = 60; p_w[3] = 2; p_h[3] = 1; p_base[3] = 9; p_key[3] = 0;
    blit("post", 4'b1100);
    chk("post order", done_order(), 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
